// File: rtl/fetch_queue_unit_if.sv
// Bundle of the fetch unit's control, instruction-memory and decode-side signals.
// master = fetch unit, slave = surrounding environment (control, imem, decode).
interface fetch_queue_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  // inst_* handshake: a word transfers on a rising edge where inst_valid && inst_ready;
  // inst_valid never depends on inst_ready, and an un-accepted head stays stable.
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          misalign;

  modport master (
    input  redirect_valid, redirect_pc, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc, misalign
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, misalign
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC, credit-limited in-order imem fetches, DEPTH-entry queue to decode.
// Optional macro FETCH_MISALIGN_TRAP_EN halts fetching after a redirect to a non-word-aligned target.
module fetch_queue_unit #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            DEPTH    = 4,
  parameter int            STEP     = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_queue_unit_if.master bus
);
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam int            PW      = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [AW-1:0] STEP_C  = AW'(STEP);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] rsp_pc;
  logic [DW-1:0] data_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] show_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW:0]   credit_sum;
  logic          run_q;
  logic          halt_q;
  logic          issue;
  logic          rsp_ok;
  logic          push;
  logic          drop;
  logic          pop;

  // Every issued fetch reserves a queue slot, so a return can never find the queue full.
  assign credit_sum = {1'b0, outstanding} + {1'b0, count};
  assign issue      = run_q && !halt_q && !bus.redirect_valid && (credit_sum < DEPTH_C);
  assign rsp_ok     = bus.imem_rvalid && (outstanding != '0);
  assign drop       = rsp_ok && (drop_cnt != '0);
  assign push       = rsp_ok && (drop_cnt == '0);
  assign pop        = bus.inst_valid && bus.inst_ready;

  // When empty, point at the most recently consumed slot so the outputs hold their last value.
  assign show_ptr      = (count != '0) ? rd_ptr : rd_ptr - PW'(1);
  assign bus.imem_req   = issue;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = data_mem[show_ptr];
  assign bus.inst_pc    = pc_mem[show_ptr];

`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.misalign = halt_q;
`else
  assign halt_q       = 1'b0;
  assign bus.misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      run_q       <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_q      <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= RESET_PC;
      end
    end else begin
      run_q <= 1'b1;
      if (bus.redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        pc_q        <= bus.redirect_pc;
        rsp_pc      <= bus.redirect_pc;
        wr_ptr      <= rd_ptr;
        count       <= '0;
        outstanding <= outstanding - CW'(rsp_ok);
        drop_cnt    <= outstanding - CW'(rsp_ok);
`ifdef FETCH_MISALIGN_TRAP_EN
        halt_q      <= (bus.redirect_pc[1:0] != 2'b00);
`endif
      end else begin
        if (issue) pc_q <= pc_q + STEP_C;
        outstanding <= outstanding + CW'(issue) - CW'(rsp_ok);
        if (drop) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          data_mem[wr_ptr] <= bus.imem_rdata;
          pc_mem[wr_ptr]   <= rsp_pc;
          wr_ptr           <= wr_ptr + PW'(1);
          rsp_pc           <= rsp_pc + STEP_C;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule
